imem_loader: RTL and testbench
==============================

# imem_loader

Program-load and instruction-memory block that feeds the CPU's fetch stage. It accepts a stream of 16-bit instruction words over a valid/ready write handshake and stores them into a DEPTH-entry instruction store. It then serves the CPU's combinational fetch read port (pc → instruction). It also holds the CPU out of execution via `cpu_run` until a complete image has been loaded.

## Interface
- `DEPTH`, 16, number of instruction words; must equal 2**AW
- `AW`, 4, fetch address width; matches the CPU `pc` width
- `DW`, 16, instruction word width
- `clk1`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `load_start`  in  1  single-cycle request to begin loading an image
- `load_len`  in  AW+1  number of words to load; sampled with `load_start`; 0 means DEPTH
- `wr_valid`  in  1  source has a word on `wr_data`
- `wr_data`  in  DW  instruction word
- `wr_ready`  out  1  block accepts a word this cycle
- `pc`  in  AW  fetch address from the CPU
- `instruction`  out  DW  fetched word
- `cpu_run`  out  1  image is loaded; CPU may execute
- `busy`  out  1  load in progress
- `load_err`  out  1  last load failed its checksum; constant 0 without IMEM_CHECKSUM_EN

## Operation
- States: IDLE, LOAD, CHECK (only with IMEM_CHECKSUM_EN), RUN.
- Reset:
  - State goes to IDLE.
  - All memory words, the write pointer, the length register and the checksum accumulator clear to 0.
  - `wr_ready`=0, `cpu_run`=0, `busy`=0, `load_err`=0, `instruction`=0.
- IDLE:
  - `load_start`=1 → LOAD.
  - On that edge: capture `load_len` (0 maps to DEPTH), clear the write pointer, clear the accumulator, clear `load_err`.
- LOAD:
  - `wr_ready`=1 and `busy`=1.
  - A transfer occurs when `wr_valid` and `wr_ready` are both high at a rising edge. Each transfer writes mem[wptr] and increments wptr.
  - Without checksum: the transfer that writes the final word (wptr = len-1) moves the state to RUN.
  - With checksum: that transfer moves the state to CHECK instead.
  - `load_start` is ignored while in LOAD.
- CHECK:
  - `wr_ready`=1 and `busy`=1.
  - The next accepted word is the checksum and is not stored in memory.
  - Checksum equals the accumulator → RUN.
  - Checksum differs → IDLE with `load_err`=1.
- RUN:
  - `cpu_run`=1.
  - `load_start`=1 → LOAD with the same capture actions as in IDLE. Memory contents beyond the new length are retained.
- Fetch port:
  - `instruction` = mem[pc] when `cpu_run`=1, otherwise 0 (NOP).
  - Addresses at or beyond the loaded length return the stored contents: 0 if never written since reset.
- Checksum arithmetic: 16-bit sum of all stored words, wrapping modulo 2^16.
- `load_err` is sticky until the next accepted `load_start` or reset.
- Reset asserted mid-load: load aborts immediately and memory clears. Any partial image is discarded.

## Timing
- `state`, `wptr` and memory are registered. `wr_ready`, `busy` and `cpu_run` decode from registered state only, with no combinational path from `wr_valid`.
- `load_start` sampled at edge N → `wr_ready`=1 during cycle N+1.
- Throughput is one word per cycle with `wr_valid` held high. Gaps in `wr_valid` stall without loss.
- Final data word (or checksum word) accepted at edge M → `cpu_run`=1 and `wr_ready`=0 from just after edge M.
- `load_start` in RUN at edge N → `cpu_run`=0 and `instruction`=0 from just after edge N.
- Fetch read is combinational: `instruction` follows `pc` in the same cycle, with no added latency.
- A word written at edge M is readable via `pc` after edge M, provided `cpu_run`=1.

## Configuration
- `IMEM_CHECKSUM_EN`:
  - Defined: CHECK state, 16-bit accumulator and `load_err` logic are present. Load length is len data words plus 1 checksum word.
  - Undefined: CHECK state and accumulator are absent, `load_err` is tied to 0, and LOAD goes directly to RUN.

## Test plan
- Reset check: hold `reset`=0 with random inputs → `wr_ready`=0, `cpu_run`=0, `busy`=0, `load_err`=0, `instruction`=0x0000.
- Back-to-back load: `load_len`=3, then 0x1234, 0x5678, 0x9ABC on consecutive cycles →
  - `wr_ready` drops after the third word and `cpu_run`=1;
  - `pc`=1 → 0x5678; `pc`=3 → 0x0000.
- Full-depth load with stalls: `load_len`=0 and 16 words 0x1000+i, with `wr_valid` low on every other cycle →
  - exactly 16 words accepted;
  - `pc`=15 → 0x100F.
- Reset mid-load: assert `reset` after 2 of 4 words → `cpu_run`=0, state IDLE, and a subsequent load of 1 word leaves `pc`=1 → 0x0000.
- Reload while running: in RUN, pulse `load_start` → `cpu_run`=0 and `instruction`=0 the next cycle, `wr_ready`=1.
- Checksum (IMEM_CHECKSUM_EN), with data 0x1234, 0x5678:
  - checksum 0x68AC → `cpu_run`=1;
  - checksum 0x0000 → `load_err`=1, state IDLE, `cpu_run`=0.

Source files
------------

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - instruction word write channel between image source and imem_loader
interface imem_loader_if #(
    parameter int DW = 16
);
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;

    // Image source drives words, loader answers with ready
    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    // Loader side of the channel
    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - program-load instruction store with fetch port; optional IMEM_CHECKSUM_EN
module imem_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              load_start,
    input  logic [AW:0]       load_len,
    imem_loader_if.slave      wr,
    input  logic [AW-1:0]     pc,
    output logic [DW-1:0]     instruction,
    output logic              cpu_run,
    output logic              busy,
    output logic              load_err
);

`ifdef IMEM_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW:0]     len;
    logic            xfer;
    logic            last_word;
    logic            start_ok;

    // Accepting-state decode comes from registered state only, never from wr_valid
`ifdef IMEM_CHECKSUM_EN
    assign wr.wr_ready = (state == S_LOAD) || (state == S_CHECK);
`else
    assign wr.wr_ready = (state == S_LOAD);
`endif
    assign busy      = wr.wr_ready;
    assign cpu_run   = (state == S_RUN);
    assign xfer      = wr.wr_valid && wr.wr_ready;
    assign last_word = ({1'b0, wptr} == (len - (AW+1)'(1)));
    assign start_ok  = load_start && ((state == S_IDLE) || (state == S_RUN));

    // Fetch is combinational and reads as NOP until an image is running
    assign instruction = cpu_run ? mem[pc] : '0;

    // State register
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [DW-1:0] acc;
    logic          err_q;

    assign load_err = err_q;

    // Running checksum of stored words and sticky error flag
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            err_q <= 1'b0;
        end else if (start_ok) begin
            acc   <= '0;
            err_q <= 1'b0;
        end else if (xfer && (state == S_LOAD)) begin
            acc <= acc + wr.wr_data;
        end else if (xfer && (state == S_CHECK) && (wr.wr_data != acc)) begin
            err_q <= 1'b1;
        end
    end
`else
    assign load_err = 1'b0;
`endif

    // Next-state: start a load, finish on the last word, verify checksum if present
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (load_start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (xfer && last_word) begin
`ifdef IMEM_CHECKSUM_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_RUN;
`endif
                end
            end
`ifdef IMEM_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) state_nxt = (wr.wr_data == acc) ? S_RUN : S_IDLE;
            end
`endif
            S_RUN: begin
                if (load_start) state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Length capture, write pointer and instruction store; reset wipes any partial image
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            len  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (start_ok) begin
            wptr <= '0;
            len  <= (load_len == '0) ? (AW+1)'(DEPTH) : load_len;
        end else if (xfer && (state == S_LOAD)) begin
            mem[wptr] <= wr.wr_data;
            wptr      <= wptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard bench for imem_loader
module tb_imem_loader;

    logic        clk1 = 1'b0;
    logic        reset;
    logic        load_start;
    logic [4:0]  load_len;
    logic [3:0]  pc;
    logic [15:0] instruction;
    logic        cpu_run;
    logic        busy;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];

    imem_loader_if #(.DW(16)) wr_if ();

    imem_loader #(.DEPTH(16), .AW(4), .DW(16)) dut (
        .clk1        (clk1),
        .reset       (reset),
        .load_start  (load_start),
        .load_len    (load_len),
        .wr          (wr_if),
        .pc          (pc),
        .instruction (instruction),
        .cpu_run     (cpu_run),
        .busy        (busy),
        .load_err    (load_err)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic start_load(input logic [4:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
        check("start_wr_ready", {31'b0, wr_if.wr_ready}, 32'd1);
        check("start_busy", {31'b0, busy}, 32'd1);
        check("start_cpu_run", {31'b0, cpu_run}, 32'd0);
    endtask

    task automatic send_word(input logic [15:0] d);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = d;
        check("send_ready", {31'b0, wr_if.wr_ready}, 32'd1);
        tick();
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic send_data(input logic [3:0] addr, input logic [15:0] d);
        sb.push_back('{addr: addr, data: d});
        send_word(d);
    endtask

    task automatic finish_load(input logic [15:0] sum);
`ifdef IMEM_CHECKSUM_EN
        check("check_not_run", {31'b0, cpu_run}, 32'd0);
        send_word(sum);
`else
        check("sum_unused", {16'b0, sum}, {16'b0, sum ^ 16'h0} & 32'hFFFF);
        checks--;
`endif
    endtask

    task automatic drain_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            pc = e.addr;
            #1;
            check($sformatf("fetch_pc%0d", e.addr), {16'b0, instruction}, {16'b0, e.data});
        end
    endtask

    initial begin
        logic [15:0] sum;
        int          accepted;
        int          idx;
        int          cyc;

        reset          = 1'b0;
        load_start     = 1'b0;
        load_len       = '0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        pc             = '0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            load_start     = 1'($urandom);
            load_len       = 5'($urandom);
            wr_if.wr_valid = 1'($urandom);
            wr_if.wr_data  = 16'($urandom);
            pc             = 4'($urandom);
            tick();
            check("rst_wr_ready", {31'b0, wr_if.wr_ready}, 32'd0);
            check("rst_cpu_run", {31'b0, cpu_run}, 32'd0);
            check("rst_busy", {31'b0, busy}, 32'd0);
            check("rst_load_err", {31'b0, load_err}, 32'd0);
            check("rst_instruction", {16'b0, instruction}, 32'd0);
        end
        load_start     = 1'b0;
        wr_if.wr_valid = 1'b0;
        pc             = '0;
        #2 reset = 1'b1;
        tick();

        // Back-to-back 3-word load
        start_load(5'd3);
        send_data(4'd0, 16'h1234);
        send_data(4'd1, 16'h5678);
        check("b2b_ready_mid", {31'b0, wr_if.wr_ready}, 32'd1);
        send_data(4'd2, 16'h9ABC);
        finish_load(16'h1234 + 16'h5678 + 16'h9ABC);
        check("b2b_ready_drop", {31'b0, wr_if.wr_ready}, 32'd0);
        check("b2b_cpu_run", {31'b0, cpu_run}, 32'd1);
        check("b2b_load_err", {31'b0, load_err}, 32'd0);
        pc = 4'd1;
        #1 check("b2b_pc1", {16'b0, instruction}, 32'h5678);
        pc = 4'd3;
        #1 check("b2b_pc3", {16'b0, instruction}, 32'h0000);
        drain_sb();

        // Full-depth load with valid low every other cycle
        start_load(5'd0);
        accepted = 0;
        idx      = 0;
        sum      = '0;
        cyc      = 0;
        while (idx < 16 && cyc < 100) begin
            if (cyc % 2 == 0) begin
                wr_if.wr_valid = 1'b1;
                wr_if.wr_data  = 16'h1000 + 16'(idx);
            end else begin
                wr_if.wr_valid = 1'b0;
            end
            if (wr_if.wr_valid && wr_if.wr_ready) begin
                sb.push_back('{addr: 4'(idx), data: 16'h1000 + 16'(idx)});
                sum = sum + 16'h1000 + 16'(idx);
                accepted++;
                idx++;
            end
            tick();
            cyc++;
        end
        wr_if.wr_valid = 1'b0;
        check("full_accepted", accepted, 32'd16);
        tick();
        finish_load(sum);
        check("full_cpu_run", {31'b0, cpu_run}, 32'd1);
        check("full_ready_drop", {31'b0, wr_if.wr_ready}, 32'd0);
        pc = 4'd15;
        #1 check("full_pc15", {16'b0, instruction}, 32'h100F);
        drain_sb();

        // Reset in the middle of a 4-word load
        start_load(5'd4);
        send_word(16'hDEAD);
        send_word(16'hBEEF);
        #2 reset = 1'b0;
        #1;
        check("midrst_cpu_run", {31'b0, cpu_run}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_wr_ready", {31'b0, wr_if.wr_ready}, 32'd0);
        #2 reset = 1'b1;
        tick();
        start_load(5'd1);
        send_data(4'd0, 16'hAAAA);
        finish_load(16'hAAAA);
        check("midrst_run", {31'b0, cpu_run}, 32'd1);
        pc = 4'd1;
        #1 check("midrst_pc1_cleared", {16'b0, instruction}, 32'h0000);
        drain_sb();

        // Reload from RUN
        pc = 4'd0;
        start_load(5'd2);
        check("reload_instr_nop", {16'b0, instruction}, 32'h0000);
        send_data(4'd0, 16'h1111);
        send_data(4'd1, 16'h2222);
        finish_load(16'h3333);
        check("reload_run", {31'b0, cpu_run}, 32'd1);
        pc = 4'd2;
        #1 check("reload_pc2_retained", {16'b0, instruction}, 32'h0000);
        drain_sb();

`ifdef IMEM_CHECKSUM_EN
        // Good and bad checksum
        start_load(5'd2);
        send_data(4'd0, 16'h1234);
        send_data(4'd1, 16'h5678);
        send_word(16'h68AC);
        check("ck_good_run", {31'b0, cpu_run}, 32'd1);
        check("ck_good_err", {31'b0, load_err}, 32'd0);
        drain_sb();
        start_load(5'd2);
        send_word(16'h1234);
        send_word(16'h5678);
        send_word(16'h0000);
        check("ck_bad_err", {31'b0, load_err}, 32'd1);
        check("ck_bad_run", {31'b0, cpu_run}, 32'd0);
        check("ck_bad_busy", {31'b0, busy}, 32'd0);
        tick();
        check("ck_bad_sticky", {31'b0, load_err}, 32'd1);
`else
        check("no_ck_err", {31'b0, load_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
